// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the byte-enable block RAM.
package ram_pkg;

    typedef enum logic {SWEEP, IDLE} sweep_state_t;

    localparam bit READ_FIRST  = 1'b0;
    localparam bit WRITE_FIRST = 1'b1;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_sweep.sv
// ram_sweep: power-on clear sweep; walks every word once, writing zero, then idles.
module ram_sweep
    import ram_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          busy,
    output logic [AW-1:0] sweep_addr,
    output logic          sweep_we
);

    sweep_state_t  state, state_nxt;
    logic [AW-1:0] cnt;
    logic          last;

    assign last       = cnt == AW'(DEPTH - 1);
    assign sweep_addr = cnt;
    assign sweep_we   = busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (busy) cnt <= cnt + AW'(1);
        end
    end

    always_comb begin
        busy      = state == SWEEP;
        state_nxt = (state == SWEEP && last) ? IDLE : state;
    end

endmodule

// File: rtl/bram.sv
// bram: single-port byte-enable RAM, valid/ready requests; RAM_CLEAR_EN adds a power-on zero sweep.
module bram
    import ram_pkg::bytes_per_word;
    import ram_pkg::READ_FIRST;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 16384,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int OUT_REG       = 0,
    parameter int WRITE_FIRST   = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [bytes_per_word(DATA_WIDTH)-1:0] we,
    input  logic [ADDRESS_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH-1:0]               data,
    output logic [DATA_WIDTH-1:0]               q,
    output logic                                q_valid,
    output logic                                busy
);

    localparam int NB = bytes_per_word(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] sweep_addr, pa;
    logic                     sweep_we, accept, in_range, v0, v1, ok0;
    logic [NB-1:0]            wbe, we0;
    logic [DATA_WIDTH-1:0]    wd, raw, d0, merged, res, s1;

`ifdef RAM_CLEAR_EN
    ram_sweep #(.DEPTH(DEPTH), .AW(ADDRESS_WIDTH)) u_sweep (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy       (busy),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we)
    );
`else
    assign busy       = 1'b0;
    assign sweep_addr = '0;
    assign sweep_we   = 1'b0;
`endif

    assign req_ready = rst_n && !busy;
    assign accept    = req_valid && req_ready;
    assign in_range  = 32'(addr) < DEPTH;
    // the sweep owns the single array port while busy
    assign pa        = busy ? sweep_addr : in_range ? addr : '0;
    assign wbe       = busy ? {NB{sweep_we}} : (accept && in_range) ? we : '0;
    assign wd        = busy ? '0 : data;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++)
            if (wbe[i]) mem[pa][8*i +: 8] <= wd[8*i +: 8];
        raw <= mem[pa];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            s1 <= '0;
        end else begin
            v0 <= accept;
            v1 <= v0;
            if (v0) s1 <= res;
        end
        we0 <= we;
        d0  <= data;
        ok0 <= in_range;
    end

    // raw is the pre-write word; write-first rebuilds the merged word from it
    always_comb begin
        merged = raw;
        for (int i = 0; i < NB; i++)
            if (we0[i]) merged[8*i +: 8] = d0[8*i +: 8];
        res = !ok0 ? '0 : (WRITE_FIRST != READ_FIRST) ? merged : raw;
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  v2;
            logic [DATA_WIDTH-1:0] s2;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v2 <= 1'b0;
                    s2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) s2 <= s1;
                end
            end
            assign q       = s2;
            assign q_valid = v2;
        end else begin : g_noreg
            assign q       = s1;
            assign q_valid = v1;
        end
    endgenerate

endmodule

// File: tb/tb_bram.sv
// tb_bram: scoreboard bench for bram (defaults, and a 32-bit/1000-word/OUT_REG/WRITE_FIRST instance).
module tb_bram;

`ifdef RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct {
        logic        dc;
        logic [31:0] d;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0, n_fail = 0, b_pulses = 0;
    exp_t qa[$], qb[$];

    logic        a_rst_n, a_valid, a_ready, a_qv, a_busy;
    logic [1:0]  a_we;
    logic [13:0] a_addr;
    logic [15:0] a_data, a_q;

    logic        b_rst_n, b_valid, b_ready, b_qv, b_busy;
    logic [3:0]  b_we;
    logic [9:0]  b_addr;
    logic [31:0] b_data, b_q;

    bram ua (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .we(a_we), .addr(a_addr), .data(a_data), .q(a_q), .q_valid(a_qv), .busy(a_busy)
    );

    bram #(.DATA_WIDTH(32), .DEPTH(1000), .OUT_REG(1), .WRITE_FIRST(1)) ub (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .we(b_we), .addr(b_addr), .data(b_data), .q(b_q), .q_valid(b_qv), .busy(b_busy)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_qv === 1'b1) begin
            if (qa.size() == 0) check("a_spurious_q_valid", 1, 0);
            else begin
                e = qa.pop_front();
                check("a_q_time", cyc, e.t);
                if (!e.dc) check("a_q", {16'h0, a_q}, e.d);
            end
        end
        if (b_qv === 1'b1) begin
            b_pulses++;
            if (qb.size() == 0) check("b_spurious_q_valid", 1, 0);
            else begin
                e = qb.pop_front();
                check("b_q_time", cyc, e.t);
                if (!e.dc) check("b_q", b_q, e.d);
            end
        end
    end

    task automatic opa(input logic [1:0] w, input logic [13:0] ad, input logic [15:0] d,
                       input logic dc, input logic [15:0] ex);
        a_valid = 1'b1; a_we = w; a_addr = ad; a_data = d;
        qa.push_back('{dc, {16'h0, ex}, cyc + 2});
        @(negedge clk);
    endtask

    task automatic opb(input logic [3:0] w, input logic [9:0] ad, input logic [31:0] d,
                       input logic [31:0] ex);
        b_valid = 1'b1; b_we = w; b_addr = ad; b_data = d;
        qb.push_back('{1'b0, ex, cyc + 3});
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int p0;
        logic [31:0] d;
        a_rst_n = 0; a_valid = 0; a_we = 0; a_addr = 0; a_data = 0;
        b_rst_n = 0; b_valid = 0; b_we = 0; b_addr = 0; b_data = 0;
        repeat (3) @(negedge clk);
        check("a_rst_q", {16'h0, a_q}, 0);
        check("a_rst_q_valid", a_qv, 0);
        check("a_rst_ready", a_ready, 0);
        check("a_rst_busy", a_busy, CLR);
        check("b_rst_q", b_q, 0);
        check("b_rst_q_valid", b_qv, 0);
        check("b_rst_ready", b_ready, 0);
        check("b_rst_busy", b_busy, CLR);

        a_rst_n = 1;
        cnt = 0;
        while (a_busy && cnt < 20000) begin cnt++; @(negedge clk); end
        check("a_sweep_cycles", cnt, CLR ? 16384 : 0);
        check("a_ready_after_sweep", a_ready, 1);
`ifdef RAM_CLEAR_EN
        opa(2'b00, 14'h3FFF, 16'h0, 1'b0, 16'h0000);
`endif
        opa(2'b11, 5, 16'hABCD, !CLR, 16'h0000);
        opa(2'b01, 5, 16'h0012, 1'b0, 16'hABCD);
        opa(2'b00, 5, 16'h0000, 1'b0, 16'hAB12);
        opa(2'b11, 7, 16'h1111, !CLR, 16'h0000);
        opa(2'b11, 7, 16'h2222, 1'b0, 16'h1111);
        opa(2'b00, 7, 16'h0000, 1'b0, 16'h2222);
        opa(2'b10, 5, 16'h5600, 1'b0, 16'hAB12);
        opa(2'b00, 5, 16'h0000, 1'b0, 16'h5612);
        a_valid = 0; a_we = 0;
        repeat (4) @(negedge clk);
        check("a_q_hold", {16'h0, a_q}, 16'h5612);
        check("a_q_valid_idle", a_qv, 0);
        check("a_queue_drained", qa.size(), 0);

        b_rst_n = 1;
        repeat (500) @(negedge clk);
        check("b_busy_mid_sweep", b_busy, CLR);
        b_rst_n = 0;
        repeat (2) @(negedge clk);
        check("b_ready_in_reset", b_ready, 0);
        b_rst_n = 1;
        cnt = 0;
        while (b_busy && cnt < 20000) begin cnt++; @(negedge clk); end
        check("b_sweep_restart_cycles", cnt, CLR ? 1000 : 0);
        check("b_ready_after_sweep", b_ready, 1);
        for (int i = 0; i < 4; i++) begin
            d = 32'h11111111 * (i + 1);
            opb(4'hF, 10'(i), d, d);
        end
        for (int i = 0; i < 4; i++) opb(4'h0, 10'(i), 32'h0, 32'h11111111 * (i + 1));
        opb(4'hF, 999, 32'h12345678, 32'h12345678);
        opb(4'hF, 1000, 32'hDEADBEEF, 32'h0);
        opb(4'h0, 1000, 32'h0, 32'h0);
        opb(4'h0, 999, 32'h0, 32'h12345678);
        opb(4'b0101, 2, 32'hAABBCCDD, 32'h33BB33DD);
        opb(4'h0, 2, 32'h0, 32'h33BB33DD);
        b_valid = 0; b_we = 0;
        repeat (5) @(negedge clk);
        check("b_queue_drained", qb.size(), 0);

        p0 = b_pulses;
        b_valid = 1; b_we = 0; b_addr = 1;
        @(negedge clk);
        b_valid = 0;
        b_rst_n = 0;
        repeat (5) @(negedge clk);
        check("b_no_q_valid_after_reset", b_pulses - p0, 0);
        b_rst_n = 1;
        cnt = 0;
        while (!b_ready && cnt < 20000) begin cnt++; @(negedge clk); end
        check("b_ready_after_resweep", b_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
